// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - segmented-carry pipelined adder/subtractor with valid/ready flow control
// An input register bank feeds STAGES segment stages; each adds one SEG-bit slice using the prior slice's registered carry.
module addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       aluc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);
    localparam int STAGES = WIDTH / SEG;

    logic [STAGES:0]  vld;
    logic [WIDTH-1:0] a_r   [0:STAGES];
    logic [WIDTH-1:0] bx_r  [0:STAGES];
    logic [WIDTH-1:0] sum_r [0:STAGES];
    logic             cy_r  [0:STAGES];
    logic [1:0]       op_r  [0:STAGES];
    logic [SEG:0]     seg_add [1:STAGES];
    logic             advance;
    logic             ovf;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] sum_f;

    // A full final stage that is not being drained freezes the whole pipe.
    assign advance  = !(vld[STAGES] && !out_ready);
    assign in_ready = advance;

    always_comb begin
        for (int k = 1; k <= STAGES; k++) begin
            seg_add[k] = {1'b0, a_r[k-1][(k-1)*SEG +: SEG]}
                       + {1'b0, bx_r[k-1][(k-1)*SEG +: SEG]}
                       + {{SEG{1'b0}}, cy_r[k-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (advance) begin
            vld <= {vld[STAGES-1:0], in_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            a_r[0]   <= a;
            bx_r[0]  <= aluc[0] ? ~b : b;
            cy_r[0]  <= aluc[0];
            op_r[0]  <= aluc;
            sum_r[0] <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                a_r[k]  <= a_r[k-1];
                bx_r[k] <= bx_r[k-1];
                op_r[k] <= op_r[k-1];
                cy_r[k] <= seg_add[k][SEG];
                sum_r[k] <= sum_r[k-1];
                sum_r[k][(k-1)*SEG +: SEG] <= seg_add[k][SEG-1:0];
            end
        end
    end

    // Flags derive only from final-stage registers, so they hold steady through a stall.
    always_comb begin
        sum_f = sum_r[STAGES];
        sa    = a_r[STAGES][WIDTH-1];
        sb    = bx_r[STAGES][WIDTH-1];
        ovf   = op_r[STAGES][1] && (sa == sb) && (sum_f[WIDTH-1] != sa);
        out_valid = vld[STAGES];
        c         = '0;
        carry     = 1'b0;
        overflow  = 1'b0;
        negative  = 1'b0;
        zero      = 1'b0;
        if (vld[STAGES]) begin
            c        = ovf ? '0 : sum_f;
            carry    = !op_r[STAGES][1] && (cy_r[STAGES] ^ op_r[STAGES][0]);
            overflow = ovf;
            negative = op_r[STAGES][1] && !ovf && sum_f[WIDTH-1];
            zero     = !ovf && (sum_f == '0);
        end
    end
endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have parameter SEG, default 8, carry-chain segment width per pipeline stage; WIDTH SHALL be an integer multiple of SEG.
REQ-003 The block SHALL derive STAGES = WIDTH/SEG, the pipeline depth; default 4.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit, operand beat present.
REQ-007 The block SHALL have port in_ready, output, 1 bit, block accepts a beat this cycle.
REQ-008 The block SHALL have port a, input, WIDTH bits, operand A.
REQ-009 The block SHALL have port b, input, WIDTH bits, operand B.
REQ-010 The block SHALL have port aluc, input, 2 bits: bit0 1=subtract/0=add, bit1 1=signed/0=unsigned.
REQ-011 The block SHALL have port out_valid, output, 1 bit, result beat present.
REQ-012 The block SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-013 The block SHALL have port c, output, WIDTH bits, result.
REQ-014 The block SHALL have ports carry, overflow, negative, zero, outputs, 1 bit each, result flags.

Function
REQ-015 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; a result SHALL be consumed on an edge where out_valid=1 and out_ready=1.
REQ-016 The adder SHALL compute a + (aluc[0] ? ~b : b) + aluc[0], split into STAGES SEG-bit segments; stage k SHALL add segment k using the registered carry-out of stage k-1, with unprocessed upper operand segments and aluc carried forward in pipeline registers.
REQ-017 Latency SHALL be exactly STAGES cycles: a beat accepted at edge N SHALL present out_valid=1 after edge N+STAGES when no stall occurs; throughput SHALL be one beat per cycle.
REQ-018 Each stage SHALL hold a valid bit; empty stages SHALL advance as bubbles, and out_valid SHALL equal the valid bit of the final stage.
REQ-019 Stall: when out_valid=1 and out_ready=0, every stage SHALL hold its contents, in_ready SHALL be 0, and c and all flags SHALL remain stable; otherwise in_ready SHALL be 1.
REQ-020 Beats SHALL exit in acceptance order with none dropped or duplicated.
REQ-021 Unsigned (aluc[1]=0): c SHALL be the WIDTH-bit sum; carry SHALL be the final carry-out for add and its inverse (borrow) for subtract; overflow and negative SHALL be 0.
REQ-022 Signed (aluc[1]=1): overflow SHALL be 1 when sign-extended result bits WIDTH and WIDTH-1 differ; on overflow c SHALL be 0, else c SHALL be the sum; carry SHALL be 0; negative SHALL equal c[WIDTH-1].
REQ-023 zero SHALL be 1 when c equals 0 and overflow is 0, else 0.
REQ-024 Outputs c and flags SHALL be don't-care-free: when out_valid=0 they SHALL be 0.

Reset
REQ-025 While rst=1, all stage valid bits, out_valid, c, carry, overflow, negative and zero SHALL be 0 immediately, independent of clk; in_ready SHALL be 1.
REQ-026 Reset asserted with beats in flight SHALL discard them; no pre-reset result SHALL appear after rst deasserts.
REQ-027 The first beat accepted after rst deasserts SHALL follow the latency of REQ-017.

Verification
REQ-028 Defaults, out_ready=1: a=0xFFFFFFFF, b=0x00000001, aluc=00 -> 4 cycles later c=0x00000000, carry=1, zero=1, overflow=0.
REQ-029 a=0x00000001, b=0x00000002, aluc=01 -> c=0xFFFFFFFF, carry=1, negative=0; then a=0x7FFFFFFF, b=0x00000001, aluc=10 -> overflow=1, c=0, negative=0, zero=0.
REQ-030 Five back-to-back beats (a=1..5, b=0x10, aluc=00), out_ready=0 for 3 cycles once first result appears -> in_ready=0 and outputs frozen during stall; results 0x11..0x15 in order, none lost.
REQ-031 Three beats in flight, rst pulsed mid-cycle -> out_valid=0 asynchronously; after release with no new input, out_valid stays 0.
REQ-032 WIDTH=16, SEG=4: a=0x8000, b=0x0001, aluc=11 -> after 4 cycles overflow=1, c=0; a=0x0005, b=0x0003, aluc=11 -> c=0x0002, overflow=0, negative=0.
